// File: rtl/led_trail_fader.sv
// Per-LED PWM driver for the walking-one pattern: lit bits run at full brightness,
// cleared bits fade out linearly, leaving a decaying trail behind the walking light.
module led_trail_fader #(
    parameter int NUM_LEDS        = 8,
    parameter int PWM_BITS        = 8,
    parameter int DECAY_TICK_BITS = 16,
    parameter int DECAY_STEP      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                pattern_valid,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                pwm_sync
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0]                pwm_cnt;
    logic [DECAY_TICK_BITS-1:0]         tick_cnt;
    logic [NUM_LEDS-1:0]                pat_reg;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  level_nxt;
    logic [NUM_LEDS-1:0]                eff_pat;
    logic [NUM_LEDS-1:0]                lit;
    logic                               tick;

    assign tick    = &tick_cnt;
    // A pattern arriving this cycle already governs which bits decay on a coincident tick.
    assign eff_pat = pattern_valid ? pattern_in : pat_reg;

    always_comb begin
        level_nxt = level;
        lit       = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (pattern_valid && pattern_in[i]) begin
                level_nxt[i] = LEVEL_MAX;
            end else if (tick && !eff_pat[i]) begin
                level_nxt[i] = (level[i] > STEP) ? (level[i] - STEP) : '0;
            end
            lit[i] = (level[i] > pwm_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            pat_reg  <= '0;
            level    <= '0;
            led_out  <= '0;
            pwm_sync <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            tick_cnt <= tick_cnt + DECAY_TICK_BITS'(1);
            pwm_sync <= &pwm_cnt;
            if (pattern_valid) begin
                pat_reg <= pattern_in;
            end
            level    <= level_nxt;
            led_out  <= enable ? lit : '0;
        end
    end

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: table of load/decay vectors plus hand sequences for
// reset, PWM period, coincident load+tick and enable gating.
module tb_led_trail_fader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pattern_in = 8'h00;
    logic       pattern_valid = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] led_out;
    logic       pwm_sync;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    led_trail_fader #(
        .NUM_LEDS(8), .PWM_BITS(8), .DECAY_TICK_BITS(4), .DECAY_STEP(16)
    ) dut (
        .clk(clk), .rst(rst), .pattern_in(pattern_in), .pattern_valid(pattern_valid),
        .enable(enable), .led_out(led_out), .pwm_sync(pwm_sync)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: edge k sees pwm_cnt=(k-1)%256, tick when k%16==0.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0]      load_a;
        logic [7:0]      load_b;
        int              ticks;
        logic [7:0][7:0] lvl;
    } vec_t;
    vec_t vecs[7];

    task automatic push_exp(input string n, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        exp_t x;
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got %0d with nothing expected", act);
        end else begin
            x = sb.pop_front();
            if (act === x.exp) n_pass++;
            else $display("FAIL %s: got %0d expected %0d", x.name, act, x.exp);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        push_exp(n, e);
        pop_cmp(act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] p);
        pattern_in    = p;
        pattern_valid = 1'b1;
        step();
        pattern_valid = 1'b0;
        pattern_in    = 8'h00;
    endtask

    task automatic align_after_tick();
        while (cyc % 16 != 0) step();
    endtask

    task automatic wait_ticks(input int n);
        int got = 0;
        while (got < n) begin
            step();
            if (cyc % 16 == 0) got++;
        end
    endtask

    task automatic run_vec(input int v);
        if (vecs[v].load_a != 8'h00) begin
            align_after_tick();
            load(vecs[v].load_a);
            load(vecs[v].load_b);
        end
        for (int i = 0; i < 8; i++) push_exp($sformatf("vec%0d_level%0d", v, i), vecs[v].lvl[i]);
        wait_ticks(vecs[v].ticks);
        for (int i = 0; i < 8; i++) pop_cmp(dut.level[i]);
    endtask

    initial begin
        int hi0, hiu, nsync, s1, s2, off_cnt, exp0, exp1, got0, got1;
        logic [7:0] exp_led;

        vecs[0] = '{8'h01, 8'h02, 1,  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd239}};
        vecs[1] = '{8'h00, 8'h00, 14, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd15}};
        vecs[2] = '{8'h00, 8'h00, 1,  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0}};
        vecs[3] = '{8'h00, 8'h00, 2,  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0}};
        vecs[4] = '{8'h7F, 8'h80, 3,  {8'd255, 8'd207, 8'd207, 8'd207, 8'd207, 8'd207, 8'd207, 8'd207}};
        vecs[5] = '{8'h0F, 8'h80, 14, {8'd255, 8'd0, 8'd0, 8'd0, 8'd31, 8'd31, 8'd31, 8'd31}};
        vecs[6] = '{8'h00, 8'h00, 2,  {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};

        // Reset held with the clock running.
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_led_out", led_out, 0);
        chk("rst_pwm_sync", pwm_sync, 0);
        chk("rst_level0", dut.level[0], 0);
        rst = 1'b0;

        // Single lit bit: full duty on bit 0, nothing elsewhere, sync every 256 cycles.
        hi0 = 0; hiu = 0; nsync = 0; s1 = -1; s2 = -1;
        push_exp("t2_duty0", 510);
        push_exp("t2_upper_lit", 0);
        push_exp("t2_sync_count", 2);
        push_exp("t2_sync_first", 256);
        push_exp("t2_sync_second", 512);
        load(8'h01);
        repeat (512) begin
            step();
            hi0 += int'(led_out[0]);
            if (led_out[7:1] != 7'h00) hiu++;
            if (pwm_sync) begin
                nsync++;
                if (s1 < 0) s1 = cyc;
                else if (s2 < 0) s2 = cyc;
            end
        end
        pop_cmp(hi0);
        pop_cmp(hiu);
        pop_cmp(nsync);
        pop_cmp(s1);
        pop_cmp(s2);

        // Linear fade of bit 0 while bit 1 stays lit.
        for (int v = 0; v < 4; v++) run_vec(v);

        // Load lands on the same edge as a tick.
        align_after_tick();
        load(8'h01);
        while ((cyc + 1) % 16 != 0) step();
        push_exp("t4_level0", 239);
        push_exp("t4_level1", 255);
        load(8'h02);
        pop_cmp(dut.level[0]);
        pop_cmp(dut.level[1]);

        // Enable gating while the fade carries on.
        wait_ticks(7);
        chk("t5_level0_before", dut.level[0], 127);
        enable = 1'b0;
        step();
        chk("t5_led_off_next_edge", led_out, 0);
        off_cnt = 0;
        for (int t = 0; t < 200 && cyc % 16 != 0; t++) begin
            step();
            if (led_out != 8'h00) off_cnt++;
        end
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_out != 8'h00) off_cnt++;
        end
        chk("t5_led_while_disabled", off_cnt, 0);
        chk("t5_level0_after_2ticks", dut.level[0], 95);
        enable = 1'b1;
        exp0 = 0; exp1 = 0; got0 = 0; got1 = 0;
        for (int k = cyc + 1; k <= cyc + 16; k++) begin
            exp0 += (95 > ((k - 1) % 256)) ? 1 : 0;
            exp1 += (255 > ((k - 1) % 256)) ? 1 : 0;
        end
        push_exp("t5_reenable_bit0_high", exp0);
        push_exp("t5_reenable_bit1_high", exp1);
        repeat (16) begin
            step();
            got0 += int'(led_out[0]);
            got1 += int'(led_out[1]);
        end
        pop_cmp(got0);
        pop_cmp(got1);

        // Independent fades, saturation at zero.
        for (int v = 4; v < 7; v++) run_vec(v);

        // Asynchronous reset mid-fade, between clock edges.
        align_after_tick();
        load(8'hFF);
        load(8'h00);
        wait_ticks(1);
        step();
        chk("t1_level0_midfade", dut.level[0], 239);
        exp_led = (239 > ((cyc - 1) % 256)) ? 8'hFF : 8'h00;
        chk("t1_led_before_reset", led_out, exp_led);
        #2 rst = 1'b1;
        #1;
        chk("t1_led_async_clear", led_out, 0);
        chk("t1_sync_async_clear", pwm_sync, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) chk($sformatf("t1_level%0d_cleared", i), dut.level[i], 0);
        chk("t1_pat_cleared", dut.pat_reg, 0);
        repeat (3) step();
        chk("t1_led_after_reset", led_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
